// File: rtl/br_flow_mux_select_wrr_sched_pkg.sv
// Shared types for the weighted round-robin select scheduler.
package br_flow_mux_select_wrr_sched_pkg;

  // Scheduler state mirrors whether the selected flow is requesting.
  typedef enum logic {
    WRR_IDLE = 1'b0,
    WRR_HOLD = 1'b1
  } wrr_state_e;

  // Per-cycle decision taken on the select/counter registers.
  typedef enum logic [1:0] {
    DEC_STAY    = 2'd0,  // backpressured, or idle with no competitor
    DEC_ADVANCE = 2'd1,  // transfer accepted, burst continues
    DEC_ROTATE  = 2'd2,  // move to the next valid flow, fresh burst
    DEC_RESTART = 2'd3   // burst spent but nobody else wants a turn
  } wrr_decision_e;

endpackage

// File: rtl/br_flow_mux_select_wrr_sched_if.sv
// Bundle of the mux push-side observation signals, burst configuration
// and scheduler outputs.
interface br_flow_mux_select_wrr_sched_if #(
  parameter int NumFlows   = 2,
  parameter int CountWidth = 4
);

  localparam int SelWidth = $clog2(NumFlows);

  logic [NumFlows-1:0]                 push_valid;
  logic [NumFlows-1:0]                 push_ready;
  logic [NumFlows-1:0][CountWidth-1:0] cfg_burst_len;
  logic [SelWidth-1:0]                 select;
  logic [CountWidth-1:0]               burst_count;
  logic                                select_active;

  // Environment side: observes the mux and provides configuration.
  modport master (
    output push_valid,
    output push_ready,
    output cfg_burst_len,
    input  select,
    input  burst_count,
    input  select_active
  );

  // Scheduler side.
  modport slave (
    input  push_valid,
    input  push_ready,
    input  cfg_burst_len,
    output select,
    output burst_count,
    output select_active
  );

endinterface

// File: rtl/br_flow_mux_select_wrr_next.sv
// Combinational next-flow finder: rotate the valid vector so the flow after
// `cur` sits at bit 0, find the first set bit, and map it back to a flow
// index. `cur` itself is never a candidate.
module br_flow_mux_select_wrr_next #(
  parameter int NumFlows = 2,
  parameter int SelWidth = $clog2(NumFlows)
) (
  input  logic [NumFlows-1:0] valid,
  input  logic [SelWidth-1:0] cur,
  output logic [SelWidth-1:0] nxt,
  output logic                none
);

  localparam int unsigned N = NumFlows;

  logic [NumFlows-2:0] rotated;

  // Rotate: candidate k is flow (cur + 1 + k) mod NumFlows.
  always_comb begin
    rotated = '0;
    for (int unsigned k = 0; k < N - 1; k++) begin
      rotated[k] = valid[SelWidth'((32'(cur) + k + 32'd1) % N)];
    end
  end

  // Find-first-set and unrotate; scanning from the far end lets the nearest
  // candidate win without an early exit.
  always_comb begin
    none = 1'b1;
    nxt  = cur;
    for (int unsigned j = 0; j < N - 1; j++) begin
      if (rotated[N-2-j]) begin
        none = 1'b0;
        nxt  = SelWidth'((32'(cur) + (N - 2 - j) + 32'd1) % N);
      end
    end
  end

endmodule

// File: rtl/br_flow_mux_select_wrr_sched.sv
// Weighted round-robin scheduler driving the binary select of a flow mux.
// Grants each flow a programmable burst of accepted transfers, holds select
// steady while the selected flow is backpressured, and rotates to the next
// valid flow with no bubble.
module br_flow_mux_select_wrr_sched
  import br_flow_mux_select_wrr_sched_pkg::*;
#(
  parameter int NumFlows   = 2,
  parameter int MaxBurst   = 8,
  parameter int CountWidth = $clog2(MaxBurst + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  br_flow_mux_select_wrr_sched_if.slave      sched
);

  localparam int SelWidth = $clog2(NumFlows);
  localparam logic [CountWidth-1:0] MaxLimit  = CountWidth'(MaxBurst);
  localparam logic [CountWidth-1:0] CountCeil = CountWidth'(MaxBurst - 1);
  localparam logic [CountWidth:0]   ExtOne    = (CountWidth + 1)'(1);

  logic [SelWidth-1:0]   select_q;
  logic [CountWidth-1:0] count_q;
  wrr_state_e            state_q;

  logic [SelWidth-1:0]   nxt;
  logic                  none;
  logic                  sel_valid;
  logic                  sel_ready;
  logic                  fire;
  logic [CountWidth-1:0] cfg_sel;
  logic [CountWidth-1:0] limit;
  logic [CountWidth-1:0] count_inc;
  logic                  exhausted;
  wrr_decision_e         decision;

  assign sel_valid = sched.push_valid[select_q];
  assign sel_ready = sched.push_ready[select_q];
  assign fire      = sel_valid & sel_ready;
  assign cfg_sel   = sched.cfg_burst_len[select_q];

  br_flow_mux_select_wrr_next #(
    .NumFlows (NumFlows)
  ) u_next (
    .valid (sched.push_valid),
    .cur   (select_q),
    .nxt   (nxt),
    .none  (none)
  );

  // Effective burst quota: zero means one, oversized values clamp.
  always_comb begin
    limit = cfg_sel;
    if (cfg_sel == '0) begin
      limit = CountWidth'(1);
    end else if (cfg_sel > MaxLimit) begin
      limit = MaxLimit;
    end
  end

  // Compare in one extra bit so count+1 cannot wrap; increment saturates.
  always_comb begin
    exhausted = ({1'b0, count_q} + ExtOne) >= {1'b0, limit};
    count_inc = (count_q >= CountCeil) ? count_q : count_q + CountWidth'(1);
  end

  // Priority-ordered decision for this cycle.
  always_comb begin
    decision = DEC_STAY;
    if (!sel_valid) begin
      decision = none ? DEC_STAY : DEC_ROTATE;
    end else if (!sel_ready) begin
      decision = DEC_STAY;
    end else if (exhausted) begin
      decision = none ? DEC_RESTART : DEC_ROTATE;
    end else begin
      decision = DEC_ADVANCE;
    end
  end

  // Select, burst counter and activity state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      select_q <= '0;
      count_q  <= '0;
      state_q  <= WRR_IDLE;
    end else begin
      state_q <= sel_valid ? WRR_HOLD : WRR_IDLE;
      unique case (decision)
        DEC_STAY:    ;
        DEC_ADVANCE: count_q <= count_inc;
        DEC_ROTATE: begin
          select_q <= nxt;
          count_q  <= '0;
        end
        DEC_RESTART: count_q <= '0;
        default:     ;
      endcase
    end
  end

  assign sched.select        = select_q;
  assign sched.burst_count   = count_q;
  assign sched.select_active = (state_q == WRR_HOLD);

  a_select_range : assert property (@(posedge clk) disable iff (rst)
    32'(select_q) < 32'(NumFlows));

  a_select_stable : assert property (@(posedge clk) disable iff (rst)
    (sel_valid && !sel_ready) |=> $stable(select_q));

  // A quota lowered mid-burst can leave the count at or above the new
  // limit for a cycle (the next fire rotates), so the count is bounded by
  // the largest quota, and by the live limit only while the quota is steady.
  a_count_ceiling : assert property (@(posedge clk) disable iff (rst)
    count_q < MaxLimit);

  a_count_limit : assert property (@(posedge clk) disable iff (rst)
    (sel_valid && $stable(select_q) && $stable(cfg_sel) && $stable(count_q)
     && $past(fire) && !$past(rst)) |-> count_q < limit);

  c_rotate   : cover property (@(posedge clk) disable iff (rst)
    decision == DEC_ROTATE);
  c_wrap     : cover property (@(posedge clk) disable iff (rst)
    decision == DEC_ROTATE && nxt < select_q);
  c_limit1   : cover property (@(posedge clk) disable iff (rst)
    fire && limit == CountWidth'(1));
  c_cfg_live : cover property (@(posedge clk) disable iff (rst)
    count_q != '0 && $changed(cfg_sel) && $stable(select_q));

endmodule
